// File: rtl/cic_pkg.sv
// Shared configuration, FSM state type and scaling helper for the CIC comb chain.
// IDW/ODW/SW fix the datapath, output and shift-select widths for every user
// of this package; NS and DM remain parameters of cic_comb_chain.
package cic_pkg;

  localparam int unsigned IDW  = 24;          // comb datapath width
  localparam int unsigned ODW  = 16;          // output width, ODW <= IDW
  localparam int unsigned SW   = 5;           // shift_sel width
  localparam int unsigned SMAX = IDW - ODW;   // largest usable right shift

  localparam logic signed [IDW:0] SAT_HI = (IDW+1)'((2 ** (ODW - 1)) - 1);
  localparam logic signed [IDW:0] SAT_LO = (IDW+1)'(-(2 ** (ODW - 1)));

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} comb_state_t;

  typedef struct packed {
    logic           sat;
    logic [ODW-1:0] data;
  } sat_res_t;

  // Round-half-up arithmetic right shift by s, then clip to ODW signed bits.
  // v is the comb output already sign-extended by one bit, so adding the
  // rounding constant can never overflow.
  function automatic sat_res_t sat_round(input logic signed [IDW:0] v,
                                         input int unsigned s);
    logic signed [IDW:0] r;
    sat_res_t            res;
    r = v;
    if (s != 0) r = r + ((IDW+1)'(1) <<< (s - 1));
    r = r >>> s;
    res.sat  = 1'b0;
    res.data = r[ODW-1:0];
    if (r > SAT_HI) begin
      res.sat  = 1'b1;
      res.data = SAT_HI[ODW-1:0];
    end else if (r < SAT_LO) begin
      res.sat  = 1'b1;
      res.data = SAT_LO[ODW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cic_comb_chain_if.sv
// Sample-stream interface of the comb chain.
//   enable    : 0 keeps the block idle and flushed
//   shift_sel : requested right shift (clamped to SMAX)
//   in_valid  : qualifies data_in, one sample per strobe
//   data_in   : signed integrator/decimator output
//   sat_clr   : clears the sticky saturation flag
//   out_valid : single-cycle strobe qualifying data_out
//   data_out  : scaled, rounded, saturated result
//   sat_flag  : sticky saturation indicator
interface cic_comb_chain_if import cic_pkg::*; ();

  logic           enable;
  logic [SW-1:0]  shift_sel;
  logic           in_valid;
  logic [IDW-1:0] data_in;
  logic           sat_clr;
  logic           out_valid;
  logic [ODW-1:0] data_out;
  logic           sat_flag;

  modport master (
    output enable, shift_sel, in_valid, data_in, sat_clr,
    input  out_valid, data_out, sat_flag
  );

  modport slave (
    input  enable, shift_sel, in_valid, data_in, sat_clr,
    output out_valid, data_out, sat_flag
  );

endinterface

// File: rtl/cic_comb_stage.sv
// One comb stage: y = x - x delayed by DM accepted samples, mod 2^IDW.
//   clk_div/reset_n : clock and async active-low reset
//   flush           : synchronous clear of delay line and output register
//   in_valid/in_tag : sample qualifier and its "emit" tag
//   in_data         : stage input
//   out_valid/out_tag/out_data : registered stage output
module cic_comb_stage import cic_pkg::*; #(
  parameter int unsigned DM = 1
) (
  input  logic           clk_div,
  input  logic           reset_n,
  input  logic           flush,
  input  logic           in_valid,
  input  logic           in_tag,
  input  logic [IDW-1:0] in_data,
  output logic           out_valid,
  output logic           out_tag,
  output logic [IDW-1:0] out_data
);

  logic [IDW-1:0] dly_q [DM];

  // Delay line and output only advance on accepted samples; valid moves every cycle.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_tag   <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < int'(DM); i++) dly_q[i] <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_tag   <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < int'(DM); i++) dly_q[i] <= '0;
    end else begin
      out_valid <= in_valid;
      out_tag   <= in_valid & in_tag;
      if (in_valid) begin
        out_data <= in_data - dly_q[DM-1];
        dly_q[0] <= in_data;
        for (int i = 1; i < int'(DM); i++) dly_q[i] <= dly_q[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_comb_chain.sv
// NS cascaded comb stages, then round/shift/saturate to ODW bits, with a
// warm-up FSM hiding transient outputs after enable or a shift change.
//   clk_div : decimated-rate clock
//   reset_n : asynchronous active-low reset
//   bus     : sample stream (see cic_comb_chain_if)
module cic_comb_chain import cic_pkg::*; #(
  parameter int unsigned NS = 3,
  parameter int unsigned DM = 1
) (
  input  logic              clk_div,
  input  logic              reset_n,
  cic_comb_chain_if.slave   bus
);

  localparam int unsigned WU = NS * DM;             // samples needed to fill all delay lines
  localparam int unsigned CW = $clog2(WU + 1);

  comb_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] shift_q;
  logic          flush_c, accept_c, tag_c, shift_chg_c, emit_c;
  int unsigned   s_eff_c;
  sat_res_t      sr_c;

  logic [IDW-1:0] stage_data  [NS+1];
  logic           stage_valid [NS+1];
  logic           stage_tag   [NS+1];

  assign shift_chg_c = (bus.shift_sel != shift_q);

  // State, warm-up counter and the reference copy of shift_sel.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= bus.shift_sel;
    end
  end

  // Next state, flush and sample acceptance; only RUN-accepted samples are tagged for output.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_c  = 1'b0;
    accept_c = 1'b0;
    tag_c    = 1'b0;
    case (state_q)
      IDLE: begin
        flush_c = 1'b1;
        cnt_d   = '0;
        if (bus.enable) state_d = WARMUP;
      end
      WARMUP, RUN: begin
        if (!bus.enable) begin
          flush_c = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (shift_chg_c) begin
          flush_c = 1'b1;
          cnt_d   = '0;
          state_d = WARMUP;
        end else if (bus.in_valid) begin
          accept_c = 1'b1;
          tag_c    = (state_q == RUN);
          if (state_q == WARMUP) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(WU)) state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stage_data[0]  = bus.data_in;
  assign stage_valid[0] = accept_c;
  assign stage_tag[0]   = tag_c;

  for (genvar k = 0; k < int'(NS); k++) begin : g_stage
    cic_comb_stage #(.DM(DM)) u_stage (
      .clk_div   (clk_div),
      .reset_n   (reset_n),
      .flush     (flush_c),
      .in_valid  (stage_valid[k]),
      .in_tag    (stage_tag[k]),
      .in_data   (stage_data[k]),
      .out_valid (stage_valid[k+1]),
      .out_tag   (stage_tag[k+1]),
      .out_data  (stage_data[k+1])
    );
  end

  // Shift amounts beyond SMAX would discard bits the output can still hold.
  always_comb begin
    s_eff_c = 32'(bus.shift_sel);
    if (s_eff_c > SMAX) s_eff_c = SMAX;
    sr_c = sat_round((IDW+1)'($signed(stage_data[NS])), s_eff_c);
  end

  assign emit_c = stage_valid[NS] & stage_tag[NS] & ~flush_c;

  // Output register; data_out holds between strobes and survives flushes.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.sat_flag  <= 1'b0;
    end else begin
      bus.out_valid <= emit_c;
      if (emit_c) bus.data_out <= sr_c.data;
      if (emit_c && sr_c.sat) bus.sat_flag <= 1'b1;
      else if (bus.sat_clr)   bus.sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_comb_chain.sv
// Self-checking bench for cic_comb_chain: directed impulse/ramp/rounding/
// saturation/shift-change sequences plus a randomized run, all compared against
// a binomial-difference reference model of the comb cascade.
module tb_cic_comb_chain;
  import cic_pkg::*;

  localparam int unsigned NS = 3;
  localparam int unsigned DM = 1;
  localparam int          WU = NS * DM;

  logic clk_div = 1'b0;
  logic reset_n;

  cic_comb_chain_if bus ();

  cic_comb_chain #(.NS(NS), .DM(DM)) dut (
    .clk_div (clk_div),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_div = ~clk_div;

  int edge_cnt = 0;
  always @(posedge clk_div) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int     edge_no;
    longint val;
    bit     sat;
  } exp_t;

  exp_t          exp_q[$];
  longint        hist[$];
  longint        seen[$];
  bit            m_active;
  logic [SW-1:0] m_prev_sh;
  bit            m_clr;
  longint        m_data;
  bit            m_sat;
  int unsigned   cur_sh;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - i + 1) / i;
    return r;
  endfunction

  // Comb cascade of NS stages = (1 - z^-DM)^NS applied to the accepted history.
  task automatic predict(input int unsigned s_raw, output longint val, output bit sat);
    longint sum, y, m, num, d, q, hi, lo;
    int unsigned s;
    sum = 0;
    for (int k = 0; k <= int'(NS); k++) begin
      int idx = hist.size() - 1 - k * int'(DM);
      if (idx >= 0) sum += ((k % 2 == 1) ? -1 : 1) * binom(NS, k) * hist[idx];
    end
    m = longint'(1) << IDW;
    y = sum % m;
    if (y < 0) y += m;
    if (y >= m / 2) y -= m;
    s = (s_raw > SMAX) ? SMAX : s_raw;
    if (s > 0) begin
      d   = longint'(1) << s;
      num = y + d / 2;
      q   = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
    end else begin
      q = y;
    end
    hi  = (longint'(1) << (ODW - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
    val = q;
    if (q > hi) begin val = hi; sat = 1'b1; end
    if (q < lo) begin val = lo; sat = 1'b1; end
  endtask

  // Drive one cycle of inputs, predict its effect, then check at the falling edge.
  task automatic step(input bit en, input int unsigned sh, input bit iv,
                      input longint d, input bit clr);
    logic [IDW-1:0] dv;
    exp_t           e;
    int             ev_edge;
    dv            = IDW'(d);
    bus.enable    = en;
    bus.shift_sel = SW'(sh);
    bus.in_valid  = iv;
    bus.data_in   = dv;
    bus.sat_clr   = clr;
    ev_edge       = edge_cnt + 1;
    if (!m_active) begin
      if (en) m_active = 1'b1;
      hist.delete();
      exp_q.delete();
    end else if (!en || (SW'(sh) != m_prev_sh)) begin
      m_active = en;
      hist.delete();
      exp_q.delete();
    end else if (iv) begin
      hist.push_back(longint'($signed(dv)));
      if (hist.size() > WU) begin
        predict(sh, e.val, e.sat);
        e.edge_no = ev_edge + int'(NS);
        exp_q.push_back(e);
      end
    end
    m_prev_sh = SW'(sh);
    m_clr     = clr;

    @(negedge clk_div);
    if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
      e = exp_q.pop_front();
      check("out_valid", longint'(bus.out_valid), 1);
      m_data = e.val;
      if (e.sat) m_sat = 1'b1;
      else if (m_clr) m_sat = 1'b0;
    end else begin
      check("out_valid", longint'(bus.out_valid), 0);
      if (m_clr) m_sat = 1'b0;
    end
    check("data_out", longint'($signed(bus.data_out)), m_data);
    check("sat_flag", longint'(bus.sat_flag), longint'(m_sat));
    if (bus.out_valid) seen.push_back(longint'($signed(bus.data_out)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, cur_sh, 1'b0, 0, 1'b0);
  endtask

  task automatic restart(input int unsigned sh);
    cur_sh = sh;
    step(1'b0, sh, 1'b0, 0, 1'b0);
    step(1'b1, sh, 1'b0, 0, 1'b0);
  endtask

  task automatic feed(input int unsigned sh, input longint vals[$]);
    cur_sh = sh;
    foreach (vals[i]) step(1'b1, sh, 1'b1, vals[i], 1'b0);
  endtask

  task automatic check_seen(input string tag, input longint want[$]);
    check($sformatf("%s_count", tag), longint'(seen.size()), longint'(want.size()));
    for (int i = 0; i < want.size() && i < seen.size(); i++)
      check($sformatf("%s[%0d]", tag, i), seen[i], want[i]);
    seen.delete();
  endtask

  task automatic rand_step();
    longint d;
    if ($urandom_range(39) == 0) cur_sh = $urandom_range(31);
    if ($urandom_range(3) == 0) d = longint'($urandom);
    else d = longint'($urandom_range(4000)) - 2000;
    step($urandom_range(63) != 0, cur_sh, $urandom_range(3) != 0, d,
         $urandom_range(19) == 0);
  endtask

  initial begin
    longint v[$];
    longint w[$];

    reset_n       = 1'b0;
    bus.enable    = 1'b0;
    bus.shift_sel = '0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.sat_clr   = 1'b0;
    m_active = 1'b0; m_prev_sh = '0; m_clr = 1'b0; m_data = 0; m_sat = 1'b0; cur_sh = 0;
    repeat (3) @(negedge clk_div);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_data_out", longint'($signed(bus.data_out)), 0);
    check("rst_sat_flag", longint'(bus.sat_flag), 0);
    reset_n = 1'b1;

    // Impulse after three zero warm-up samples.
    restart(0);
    seen.delete();
    v = '{0, 0, 0, 1, 0, 0, 0, 0};
    feed(0, v);
    idle(NS + 2);
    w = '{1, -3, 3, -1, 0};
    check_seen("impulse", w);

    // Linear and quadratic ramps both vanish after the third difference.
    restart(0);
    v.delete();
    for (int n = 0; n <= 20; n++) v.push_back(n);
    feed(0, v);
    idle(NS + 2);
    w.delete();
    for (int n = 0; n < 18; n++) w.push_back(0);
    check_seen("ramp", w);
    restart(0);
    v.delete();
    for (int n = 0; n <= 20; n++) v.push_back(n * n);
    feed(0, v);
    idle(NS + 2);
    check_seen("ramp_sq", w);

    // Round-half-up with s = 4 on positive and negative steps.
    restart(4);
    v = '{0, 0, 0, 24, 24, 24, 24};
    feed(4, v);
    idle(NS + 2);
    w = '{2, -3, 2, 0};
    check_seen("round_pos", w);
    restart(4);
    v = '{0, 0, 0, -24, -24, -24, -24};
    feed(4, v);
    idle(NS + 2);
    w = '{-1, 3, -1, 0};
    check_seen("round_neg", w);

    // Saturation at both rails, then sticky flag cleared.
    restart(0);
    v = '{0, 0, 0, 40000, 40000, 40000, 40000};
    feed(0, v);
    idle(NS + 2);
    w = '{32767, -32768, 32767, 0};
    check_seen("sat_pos", w);
    check("sat_set", longint'(bus.sat_flag), 1);
    restart(0);
    v = '{0, 0, 0, -40000, -40000};
    feed(0, v);
    idle(NS + 2);
    w = '{-32768, 32767};
    check_seen("sat_neg", w);
    step(1'b1, 0, 1'b0, 0, 1'b1);
    check("sat_clr", longint'(bus.sat_flag), 0);

    // Shift change in RUN: the next WU accepted samples are suppressed.
    restart(0);
    v = '{5, -7, 11, 130, -260, 17};
    feed(0, v);
    idle(NS + 2);
    seen.delete();
    step(1'b1, 2, 1'b0, 0, 1'b0);
    v = '{100, 200, -300, 400, -500, 600, 700, -800, 900, 1000};
    feed(2, v);
    idle(NS + 2);
    check("shift_warm_count", longint'(seen.size()), longint'(10 - WU));
    seen.delete();

    // Randomized traffic with enable drops, shift changes and clears.
    for (int i = 0; i < 1500; i++) rand_step();

    // Asynchronous reset while data is in flight.
    restart(0);
    v = '{0, 0, 0, 40000, 40000};
    feed(0, v);
    idle(NS + 2);
    v = '{321, -654, 987};
    feed(0, v);
    check("pre_rst_sat", longint'(bus.sat_flag), 1);
    bus.in_valid = 1'b1;
    bus.data_in  = IDW'(1234);
    #2 reset_n = 1'b0;
    #1;
    check("async_out_valid", longint'(bus.out_valid), 0);
    check("async_data_out", longint'($signed(bus.data_out)), 0);
    check("async_sat_flag", longint'(bus.sat_flag), 0);
    m_active = 1'b0; hist.delete(); exp_q.delete();
    m_data = 0; m_sat = 1'b0; m_clr = 1'b0;
    repeat (2) @(posedge clk_div);
    @(negedge clk_div);
    reset_n = 1'b1;
    for (int i = 0; i < 300; i++) rand_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
